// File: rtl/pix_pkg.sv
// Shared widths and state encoding for the 12-bit pixel to 16-bit word packer.
package pix_pkg;

    localparam int PixelWidth = 12;
    localparam int WordWidth  = 16;
    localparam int AccWidth   = 28;
    localparam int CntWidth   = $clog2(AccWidth);

    typedef enum logic [1:0] {
        Run,
        Drain,
        Done
    } state_e;

endpackage

// File: rtl/pix_packer.sv
// Pops 12-bit pixels from a show-ahead FIFO and packs them little-endian into
// 16-bit words on a valid/ready stream, with burst marking and flush draining.
module pix_packer
    import pix_pkg::*;
#(
    parameter int BurstWords = 256
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  rempty,
    input  logic [PixelWidth-1:0] rd,
    output logic                  r,
    output logic                  outValid,
    output logic [WordWidth-1:0]  outData,
    output logic                  outLast,
    input  logic                  outReady,
    input  logic                  flush,
    output logic                  flushDone
);

    localparam int                  WcWidth  = $clog2(BurstWords);
    localparam logic [WcWidth-1:0]  LastIdx  = WcWidth'(BurstWords - 1);
    localparam logic [CntWidth-1:0] WordBits = CntWidth'(WordWidth);
    localparam logic [CntWidth-1:0] PixBits  = CntWidth'(PixelWidth);

    state_e                state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d, acc_e;
    logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_e;
    logic [WcWidth-1:0]    wcnt_q, wcnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [WordWidth-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  flush_done_q, flush_done_d;
    logic                  slot_free, emit_full, emit_pad, burst_last, pull;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        flush_done_d = 1'b0;

        slot_free  = !out_valid_q || outReady;
        emit_full  = slot_free && (state_q != Done) && (cnt_q >= WordBits);
        emit_pad   = slot_free && (state_q == Drain) && (cnt_q != '0) && (cnt_q < WordBits);
        burst_last = (wcnt_q == LastIdx);

        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        // Bits above cnt are always zero, so the low half is already the padded word.
        if (emit_full || emit_pad) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[WordWidth-1:0];
            out_last_d  = burst_last || emit_pad || ((state_q == Drain) && (cnt_q == WordBits));
            wcnt_d      = burst_last ? '0 : wcnt_q + WcWidth'(1);
        end

        acc_e = acc_q;
        cnt_e = cnt_q;
        if (emit_full) begin
            acc_e = acc_q >> WordWidth;
            cnt_e = cnt_q - WordBits;
        end else if (emit_pad) begin
            acc_e = '0;
            cnt_e = '0;
        end

        // Pop is gated by rst_ so the FIFO is never drained while reset is held.
        pull  = rst_ && (state_q == Run) && !flush && !rempty && (cnt_e < WordBits);
        r     = pull;
        acc_d = acc_e;
        cnt_d = cnt_e;
        if (pull) begin
            acc_d = acc_e | (AccWidth'(rd) << cnt_e);
            cnt_d = cnt_e + PixBits;
        end

        case (state_q)
            Run: begin
                if (flush) state_d = Drain;
            end
            Drain: begin
                if (cnt_e == '0) state_d = Done;
            end
            Done: begin
                if (slot_free) begin
                    flush_done_d = 1'b1;
                    wcnt_d       = '0;
                    state_d      = Run;
                end
            end
            default: state_d = Run;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= Run;
            acc_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign outValid  = out_valid_q;
    assign outData   = out_data_q;
    assign outLast   = out_last_q;
    assign flushDone = flush_done_q;

endmodule

// File: tb/tb_pix_packer.sv
// Directed bench for pix_packer: a queue models the show-ahead FIFO, accepted
// words are collected and compared against hand values and a bit-packing model.
module tb_pix_packer;

    localparam int Bw = 4;

    logic        clk = 1'b0;
    logic        rst_;
    logic        rempty;
    logic [11:0] rd;
    logic        r;
    logic        outValid;
    logic [15:0] outData;
    logic        outLast;
    logic        outReady;
    logic        flush;
    logic        flushDone;

    pix_packer #(.BurstWords(Bw)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .rempty   (rempty),
        .rd       (rd),
        .r        (r),
        .outValid (outValid),
        .outData  (outData),
        .outLast  (outLast),
        .outReady (outReady),
        .flush    (flush),
        .flushDone(flushDone)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][11:0] pix;
        logic [2:0][15:0] word;
    } pack_vec_t;

    pack_vec_t   vecs [4];
    logic [11:0] fifo_q [$];
    logic [11:0] sent_q [$];
    logic [15:0] got_data [$];
    logic        got_last [$];
    logic [15:0] model_q [$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        s_pop, s_valid, s_last, s_fd;
    logic [15:0] s_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] gw(input int i);
        return (i < got_data.size()) ? got_data[i] : 16'hxxxx;
    endfunction

    function automatic logic gl(input int i);
        return (i < got_last.size()) ? got_last[i] : 1'bx;
    endfunction

    task automatic push(input logic [11:0] px);
        fifo_q.push_back(px);
        sent_q.push_back(px);
    endtask

    // One clock: drive FIFO head at negedge, sample mid-phase, commit at posedge.
    task automatic step();
        rempty = (fifo_q.size() == 0);
        rd     = rempty ? 12'h000 : fifo_q[0];
        #1;
        s_pop   = r;
        s_valid = outValid;
        s_data  = outData;
        s_last  = outLast;
        s_fd    = flushDone;
        @(posedge clk);
        if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (s_valid && outReady) begin
            got_data.push_back(s_data);
            got_last.push_back(s_last);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_     = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        rempty   = 1'b1;
        rd       = 12'h000;
        fifo_q.delete();
        sent_q.delete();
        got_data.delete();
        got_last.delete();
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic run_words(input int n, input int budget);
        for (int k = 0; k < budget && got_data.size() < n; k++) step();
    endtask

    // Steps until flushDone has been seen plus three more cycles (bounded).
    task automatic run_flush(output int acc_cyc, output int fd_cyc, output int fd_count,
                             output int pops_before, output logic pop_after);
        int n0;
        acc_cyc = -1; fd_cyc = -1; fd_count = 0; pops_before = 0; pop_after = 1'b0;
        for (int k = 0; k < 30; k++) begin
            n0 = got_data.size();
            step();
            if (fd_cyc >= 0 && cyc == fd_cyc + 1) pop_after = s_pop;
            if (s_fd) begin
                fd_count++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
            if (fd_cyc < 0) begin
                if (s_pop) pops_before++;
                if (got_data.size() > n0) acc_cyc = cyc;
            end
            if (fd_cyc >= 0 && cyc - fd_cyc >= 3) break;
        end
    endtask

    task automatic build_model(input int n, input bit pad);
        logic [31:0] acc;
        int          nb;
        acc = '0;
        nb  = 0;
        model_q.delete();
        for (int i = 0; i < n; i++) begin
            acc = acc | (32'(sent_q[i]) << nb);
            nb += 12;
            while (nb >= 16) begin
                model_q.push_back(acc[15:0]);
                acc = acc >> 16;
                nb -= 16;
            end
        end
        if (pad && nb > 0) model_q.push_back(acc[15:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first_pop, last_pop, npop, hold_bad;
        int   acc_cyc, fd_cyc, fd_count, pops_before;
        logic pop_after;

        vecs[0] = '{pix: {12'hABC, 12'h789, 12'h456, 12'h123}, word: {16'hABC7, 16'h8945, 16'h6123}};
        vecs[1] = '{pix: {12'h000, 12'hFFF, 12'h000, 12'hFFF}, word: {16'h000F, 16'hFF00, 16'h0FFF}};
        vecs[2] = '{pix: {12'h5A5, 12'h00A, 12'h800, 12'h001}, word: {16'h5A50, 16'h0A80, 16'h0001}};
        vecs[3] = '{pix: {12'h456, 12'h123, 12'hDEF, 12'hABC}, word: {16'h4561, 16'h23DE, 16'hFABC}};

        // Reset state, with a non-empty FIFO so r has a reason to rise.
        rst_ = 1'b0; flush = 1'b0; outReady = 1'b1; rempty = 1'b0; rd = 12'h555;
        repeat (2) @(negedge clk);
        #1;
        check("rst_r", r, 0);
        check("rst_outValid", outValid, 0);
        check("rst_outData", outData, 0);
        check("rst_outLast", outLast, 0);
        check("rst_flushDone", flushDone, 0);

        // Basic packing, table driven.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) push(vecs[v].pix[i]);
            first_pop = -1; last_pop = -1; npop = 0;
            for (int k = 0; k < 20 && got_data.size() < 3; k++) begin
                step();
                if (s_pop) begin
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    npop++;
                end
            end
            repeat (3) step();
            check($sformatf("pack%0d_nwords", v), got_data.size(), 3);
            check($sformatf("pack%0d_npops", v), npop, 4);
            check($sformatf("pack%0d_pop_span", v), last_pop - first_pop, 3);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("pack%0d_word%0d", v, i), gw(i), vecs[v].word[i]);
                check($sformatf("pack%0d_last%0d", v, i), gl(i), 0);
            end
        end

        // Flush with padding of a single pixel.
        do_reset();
        push(12'hFFF);
        repeat (4) step();
        flush = 1'b1; step(); flush = 1'b0;
        run_flush(acc_cyc, fd_cyc, fd_count, pops_before, pop_after);
        check("fpad_nwords", got_data.size(), 1);
        check("fpad_word", gw(0), 16'h0FFF);
        check("fpad_last", gl(0), 1);
        check("fpad_fd_count", fd_count, 1);
        check("fpad_fd_delay", fd_cyc - acc_cyc, 1);

        // Second flush leaves the word counter non-zero before Done clears it.
        got_data.delete(); got_last.delete();
        push(12'h111); push(12'h222);
        repeat (6) step();
        flush = 1'b1; step(); flush = 1'b0;
        run_flush(acc_cyc, fd_cyc, fd_count, pops_before, pop_after);
        check("fclr_nwords", got_data.size(), 2);
        check("fclr_word0", gw(0), 16'h2111);
        check("fclr_last0", gl(0), 0);
        check("fclr_word1", gw(1), 16'h0022);
        check("fclr_last1", gl(1), 1);
        got_data.delete(); got_last.delete();
        for (int i = 0; i < 8; i++) push(12'(i));
        run_words(6, 40);
        check("fclr_after_nwords", got_data.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("fclr_after_last%0d", i), gl(i), (i == 3) ? 1 : 0);

        // Backpressure: FIFO full of pixels, sink stalled for 10 cycles.
        do_reset();
        outReady = 1'b0;
        push(12'hA01); push(12'hB02); push(12'hC03); push(12'hD04);
        push(12'hE05); push(12'hF06); push(12'h107); push(12'h208);
        npop = 0; hold_bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_pop) npop++;
            if (s_valid && s_data !== 16'h2A01) hold_bad++;
        end
        check("bp_npops", npop, 3);
        check("bp_r_idle", s_pop, 0);
        check("bp_valid_held", s_valid, 1);
        check("bp_data_unstable_cycles", hold_bad, 0);
        check("bp_held_data", s_data, 16'h2A01);
        outReady = 1'b1;
        run_words(6, 40);
        build_model(8, 1'b0);
        check("bp_nwords", got_data.size(), 6);
        check("bp_fifo_drained", fifo_q.size(), 0);
        for (int i = 0; i < 6; i++) check($sformatf("bp_word%0d", i), gw(i), model_q[i]);

        // Burst marking with BurstWords=4.
        do_reset();
        for (int i = 0; i < 16; i++) push(12'(i));
        run_words(12, 60);
        build_model(16, 1'b0);
        check("burst_nwords", got_data.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("burst_word%0d", i), gw(i), model_q[i]);
            check($sformatf("burst_last%0d", i), gl(i), (i % 4 == 3) ? 1 : 0);
        end

        // Flush while the FIFO still has pixels pending.
        do_reset();
        for (int i = 0; i < 20; i++) push(12'h3A0 + 12'(i));
        repeat (3) step();
        flush = 1'b1; step(); flush = 1'b0;
        check("fpend_r_flush_cycle", s_pop, 0);
        run_flush(acc_cyc, fd_cyc, fd_count, pops_before, pop_after);
        check("fpend_fd_count", fd_count, 1);
        check("fpend_pops_during_drain", pops_before, 0);
        check("fpend_pop_resumes", pop_after, 1);
        build_model(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fpend_word%0d", i), gw(i), model_q[i]);
            check($sformatf("fpend_last%0d", i), gl(i), (i == 2) ? 1 : 0);
        end

        // Reset mid-word: cnt=8 with a held output word.
        do_reset();
        outReady = 1'b0;
        push(12'h0F0); push(12'h0E1);
        repeat (5) step();
        check("rmid_valid_before", s_valid, 1);
        check("rmid_data_before", s_data, 16'h10F0);
        rempty = 1'b0; rd = 12'h777;
        #2;
        rst_ = 1'b0;
        #1;
        check("rmid_r", r, 0);
        check("rmid_outValid", outValid, 0);
        check("rmid_outData", outData, 0);
        check("rmid_outLast", outLast, 0);
        check("rmid_flushDone", flushDone, 0);
        @(negedge clk);
        rst_ = 1'b1;
        fifo_q.delete(); sent_q.delete(); got_data.delete(); got_last.delete();
        outReady = 1'b1;
        push(12'hABC);
        repeat (4) step();
        flush = 1'b1; step(); flush = 1'b0;
        run_flush(acc_cyc, fd_cyc, fd_count, pops_before, pop_after);
        check("rmid_nwords", got_data.size(), 1);
        check("rmid_word", gw(0), 16'h0ABC);
        check("rmid_last", gl(0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
